// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer: per-channel FSM state encoding
// and synchronizer depth. The state encoding puts the accepted level in bit 1.
package debounce_pkg;

    // Bit 1 of the encoding is the accepted (debounced) level, so db_out is a plain state bit.
    typedef enum logic [1:0] {
        ST_LO   = 2'b00,
        WAIT_HI = 2'b01,
        ST_HI   = 2'b10,
        WAIT_LO = 2'b11
    } db_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic logic level_of(input db_state_t st);
        return st[1];
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: SYNC_STAGES-deep synchronizer followed by a counter-based FSM.
// Edge pulses rise_p/fall_p exist only when DEBOUNCE_EDGE_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_out
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic rise_p,
    output logic fall_p
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    db_state_t              state_reg;
    db_state_t              state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter only advances below CNT_LAST, so it can never wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_LO: begin
                if (s) begin
                    state_next = WAIT_HI;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_next = ST_LO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s) begin
                    state_next = WAIT_LO;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_LO;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        db_out = level_of(state_reg);
    end

`ifdef DEBOUNCE_EDGE_EN
    logic rise_reg;
    logic fall_reg;

    // Pulses are computed from the level about to be registered, so they land on the db_out edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= !level_of(state_reg) &&  level_of(state_next);
            fall_reg <=  level_of(state_reg) && !level_of(state_next);
        end
    end

    assign rise_p = rise_reg;
    assign fall_p = fall_reg;
`endif

endmodule

// File: rtl/input_debouncer.sv
// N_CH independent debounce channels for raw switch/button levels.
// Optional feature macro: DEBOUNCE_EDGE_EN adds the rise_p/fall_p pulse ports.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] db_out
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [N_CH-1:0] rise_p,
    output logic [N_CH-1:0] fall_p
`endif
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .raw_in(raw_in[gi]),
                .db_out(db_out[gi])
`ifdef DEBOUNCE_EDGE_EN
                ,
                .rise_p(rise_p[gi]),
                .fall_p(fall_p[gi])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4, N_CH=2.
// Edge-pulse checks are compiled only when DEBOUNCE_EDGE_EN is defined.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] raw_in;
    logic [1:0] db_out;
`ifdef DEBOUNCE_EDGE_EN
    logic [1:0] rise_p;
    logic [1:0] fall_p;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .N_CH(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw_in(raw_in),
        .db_out(db_out)
`ifdef DEBOUNCE_EDGE_EN
        ,
        .rise_p(rise_p),
        .fall_p(fall_p)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge and step 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [1:0] v, input string tag);
        raw_in = v;
        for (int i = 0; i < 8; i++) tick();
        check_val(tag, 32'(db_out), 32'(v));
    endtask

    initial begin
        int and_rise;
        int and_fall;
        logic and_prev;

        rst    = 1'b1;
        raw_in = 2'b11;

        // Reset held two cycles with both raw inputs high.
        for (int i = 1; i <= 2; i++) begin
            tick();
            check_val($sformatf("reset_hold_%0d", i), 32'(db_out), 32'h0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("post_reset_e%0d", i), 32'(db_out), (i == 6) ? 32'h3 : 32'h0);
        end

        // Clean press on channel 0 only.
        settle(2'b00, "settle_00_a");
        raw_in = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("press0_e%0d", i), 32'(db_out), (i == 6) ? 32'h1 : 32'h0);
        end

        // 3-cycle high glitch on channel 1.
        raw_in = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) raw_in = 2'b01;
            check_val($sformatf("glitch_hi1_%0d", i), 32'(db_out), 32'h1);
        end

        // 3-cycle low dip on channel 1 while it is high.
        settle(2'b11, "settle_11");
        raw_in = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) raw_in = 2'b11;
            check_val($sformatf("glitch_lo1_%0d", i), 32'(db_out), 32'h3);
        end

        // Simultaneous rise; the AND gate behind the outputs must rise exactly once.
        settle(2'b00, "settle_00_b");
        raw_in   = 2'b11;
        and_rise = 0;
        and_fall = 0;
        and_prev = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_val($sformatf("simul_e%0d", i), 32'(db_out), (i >= 6) ? 32'h3 : 32'h0);
            if (!and_prev && (db_out[0] & db_out[1])) and_rise++;
            if (and_prev && !(db_out[0] & db_out[1])) and_fall++;
            and_prev = db_out[0] & db_out[1];
        end
        check_val("gate_rise_count", 32'(and_rise), 32'd1);
        check_val("gate_fall_count", 32'(and_fall), 32'd0);

        // Reset while channel 0 is in WAIT_HI with cnt=2.
        settle(2'b00, "settle_00_c");
        raw_in = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val($sformatf("pre_rst_e%0d", i), 32'(db_out), 32'h0);
        end
        rst = 1'b1;
        tick();
        check_val("mid_rst", 32'(db_out), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("restart_e%0d", i), 32'(db_out), (i == 6) ? 32'h1 : 32'h0);
        end

`ifdef DEBOUNCE_EDGE_EN
        begin
            int n_rise;
            int n_fall;
            n_rise = 0;
            n_fall = 0;
            // Release then press channel 0; pulses must coincide with the db_out change.
            raw_in = 2'b00;
            for (int i = 1; i <= 9; i++) begin
                tick();
                check_val($sformatf("rel_db_e%0d", i), 32'(db_out[0]), (i >= 6) ? 32'h0 : 32'h1);
                check_val($sformatf("rel_fall_e%0d", i), 32'(fall_p[0]), (i == 6) ? 32'h1 : 32'h0);
                n_fall += int'(fall_p[0]);
                n_rise += int'(rise_p[0]);
            end
            raw_in = 2'b01;
            for (int i = 1; i <= 9; i++) begin
                tick();
                check_val($sformatf("prs_db_e%0d", i), 32'(db_out[0]), (i >= 6) ? 32'h1 : 32'h0);
                check_val($sformatf("prs_rise_e%0d", i), 32'(rise_p[0]), (i == 6) ? 32'h1 : 32'h0);
                n_fall += int'(fall_p[0]);
                n_rise += int'(rise_p[0]);
            end
            check_val("rise_pulse_count", 32'(n_rise), 32'd1);
            check_val("fall_pulse_count", 32'(n_fall), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
